// File: rtl/poly_addsub_if.sv
// Command/data bundle for the serial coefficient protocol shared with the NTT core.
// The initiator drives the pulses and din; the processing element answers on dout/done/busy.
interface poly_addsub_if #(
  parameter int W = 12
);
  logic         load_a_f;
  logic         load_b_f;
  logic         read_a;
  logic         start_add;
  logic         start_sub;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         done;
  logic         busy;

  modport master (
    output load_a_f, load_b_f, read_a, start_add, start_sub, din,
    input  dout, done, busy
  );

  modport slave (
    input  load_a_f, load_b_f, read_a, start_add, start_sub, din,
    output dout, done, busy
  );
endinterface

// File: rtl/poly_addsub_pe.sv
// Coefficient-wise A := (A +/- B) mod Q over two N-word polynomial buffers,
// speaking the same load/read/start/done serial protocol as the NTT core.
module poly_addsub_pe #(
  parameter int N = 256,
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic          clk,
  input  logic          reset,
  poly_addsub_if.slave  bus
);

  localparam int AW = $clog2(N);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] ARITH  = 3'd3;
  localparam logic [2:0] READ   = 3'd4;

  localparam logic [W:0]  Q_EXT    = (W+1)'(Q);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(N - 1);
  localparam logic [AW:0] CNT_END  = (AW+1)'(N);

  logic [2:0]    state;
  logic [AW:0]   cnt;
  logic          op_sub;
  logic [W-1:0]  dout_r;
  logic          done_r;

  logic [W-1:0]  mem_a [N];
  logic [W-1:0]  mem_b [N];

  logic [W-1:0]  res_q;
  logic [AW-1:0] wr_addr;
  logic          wr_vld;

  logic [AW-1:0] cnt_addr;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  rd_a;
  logic [W-1:0]  rd_b;
  logic [W-1:0]  din_red;
  logic [W:0]    sum;
  logic [W:0]    diff;
  logic [W-1:0]  arith_res;

  // Loads fill from the top address down, so the first word lands at N-1.
  assign cnt_addr  = cnt[AW-1:0];
  assign load_addr = AW'(N - 1) - cnt_addr;

  // Both arrays share one read address; reads are combinational, the
  // result is captured in a register before it reaches memory or dout.
  assign rd_a = mem_a[cnt_addr];
  assign rd_b = mem_b[cnt_addr];

  // A single conditional subtract is enough: 2^W - 1 < 2*Q.
  assign din_red = ({1'b0, bus.din} >= Q_EXT) ? W'({1'b0, bus.din} - Q_EXT)
                                              : bus.din;

  always_comb begin
    sum       = {1'b0, rd_a} + {1'b0, rd_b};
    diff      = {1'b0, rd_a} - {1'b0, rd_b};
    arith_res = '0;
    if (op_sub) begin
      // diff[W] is the borrow out, i.e. a < b.
      arith_res = diff[W] ? W'(diff + Q_EXT) : diff[W-1:0];
    end else begin
      arith_res = (sum >= Q_EXT) ? W'(sum - Q_EXT) : sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_sub  <= 1'b0;
      dout_r  <= '0;
      done_r  <= 1'b0;
      res_q   <= '0;
      wr_addr <= '0;
      wr_vld  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      wr_vld <= 1'b0;
      dout_r <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.load_a_f) begin
            state <= LOAD_A;
          end else if (bus.load_b_f) begin
            state <= LOAD_B;
          end else if (bus.read_a) begin
            // Word 0 is presented in the very first READ cycle.
            state  <= READ;
            dout_r <= rd_a;
            cnt    <= (AW+1)'(1);
          end else if (bus.start_add) begin
            state  <= ARITH;
            op_sub <= 1'b0;
          end else if (bus.start_sub) begin
            state  <= ARITH;
            op_sub <= 1'b1;
          end
        end

        LOAD_A, LOAD_B: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // One extra cycle drains the result register into A[N-1].
        ARITH: begin
          if (cnt == CNT_END) begin
            state  <= IDLE;
            cnt    <= '0;
            done_r <= 1'b1;
          end else begin
            res_q   <= arith_res;
            wr_addr <= cnt_addr;
            wr_vld  <= 1'b1;
            cnt     <= cnt + 1'b1;
          end
        end

        READ: begin
          if (cnt == CNT_END) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            dout_r <= rd_a;
            cnt    <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage is never cleared; reset only suppresses the write on its edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD_A) begin
        mem_a[load_addr] <= din_red;
      end else if (wr_vld) begin
        mem_a[wr_addr] <= res_q;
      end
      if (state == LOAD_B) begin
        mem_b[load_addr] <= din_red;
      end
    end
  end

  assign bus.dout = dout_r;
  assign bus.done = done_r;
  assign bus.busy = (state != IDLE);

endmodule

// File: doc/poly_addsub_pe.md
Name: poly_addsub_pe

Overview:
- Responder-side processing element that implements the same serial coefficient protocol as the NTT core: load pulses, 12-bit din/dout streams, start pulses, done pulse.
- Holds two polynomials, A and B, and computes A := (A + B) mod q or A := (A − B) mod q coefficient by coefficient.
- The KEM datapath uses it for the Decap v − sᵀu step and for the Encap additions.
- Any existing initiator can drive it without modification.

Parameters:
- N, 256, coefficients per polynomial.
- W, 12, coefficient width in bits.
- Q, 3329, modulus.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- load_a_f  in  1  one-cycle pulse; starts a 256-word load into A.
- load_b_f  in  1  one-cycle pulse; starts a 256-word load into B.
- read_a  in  1  one-cycle pulse; starts a 256-word readout of A.
- start_add  in  1  one-cycle pulse; A := A + B mod Q.
- start_sub  in  1  one-cycle pulse; A := A − B mod Q.
- din  in  W  load data.
- dout  out  W  read data, registered.
- done  out  1  one-cycle pulse at the end of an arithmetic pass.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE, all counters 0, dout=0, done=0, busy=0. Memory contents are not cleared and are undefined after reset.
- Reset asserted mid-operation aborts in the same edge; the next command is accepted in the first cycle after reset deasserts.
- Storage: two 256×12 arrays, A and B; one read and one write per array per cycle.
- FSM states: IDLE, LOAD_A, LOAD_B, ARITH, READ.
- Commands are accepted only in IDLE; pulses in other states are ignored.
- Simultaneous pulses in IDLE: priority is load_a_f > load_b_f > read_a > start_add > start_sub. Lower-priority pulses are dropped.
- LOAD (pulse at cycle 0):
  - din is sampled in cycles 1..256.
  - The word sampled at cycle k is written to address 256−k, so the first word goes to addr 255 and the last to addr 0.
  - On load, din ≥ Q is stored as din − Q (single conditional subtract; 4095 becomes 766). Values below Q are stored unchanged.
  - Returns to IDLE after cycle 256; a new command is accepted from cycle 257.
- ARITH (pulse at cycle 0):
  - Addresses 0..255 are read in cycles 1..256.
  - A 1-stage pipeline follows: results are written to A[i] in cycle i+2.
  - done=1 in cycle 258 only; IDLE (busy=0) from cycle 258.
  - add: s = a + b (13 bits); result = s − Q if s ≥ Q, else s.
  - sub: d = a − b; result = d + Q if a < b, else d.
  - B is unchanged by either operation.
- READ (pulse at cycle 0):
  - dout = A[k] in cycle k+1, for k = 0..255 (ascending address).
  - dout=0 from cycle 257 and at all times outside READ.
  - busy drops in cycle 257.
- done is never asserted for LOAD or READ.
- A back-to-back command issued on the first IDLE cycle incurs no bubble.
- busy is a pure function of the state register.

Test Plan:
- reset; load A with words 0..255 (word k=k); read_a -> dout sequence 255,254,...,0, then dout=0 at cycle 257; done stays 0.
- load A all 3328, load B all 1; start_add -> done single pulse at cycle 258; readout all 0 (wrap-around).
- load A all 5, load B all 7; start_sub -> readout all 3327. Then B all 5, start_sub -> readout all 3322; B verified unchanged via a readout after swapping roles with a load.
- din=4095 on every load word -> stored 766; A=766, B=766, start_add -> readout all 1532. Random reduced vectors, 1000 add/sub passes -> match a mod-Q golden model.
- load_a_f and start_add pulsed in the same IDLE cycle -> load only, no done. start_add pulsed during LOAD_B or ARITH -> ignored, exactly one done per accepted pass.
- reset asserted at cycle 100 of ARITH -> busy=0, done=0, dout=0 the next cycle. A fresh load/add/read completes correctly afterwards.
